// File: rtl/udp_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_echo_pkg
// Description : Shared types and constants for the UDP echo responder.
//               It holds the metadata field offsets, the 176-bit metadata
//               struct and the responder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_echo_pkg;

    localparam int META_WIDTH     = 176;

    // Metadata field offsets (LSB positions), MSB-first layout:
    // length | their_port | my_port | their_address
    localparam int LEN_LSB        = 160;
    localparam int THEIR_PORT_LSB = 144;
    localparam int MY_PORT_LSB    = 128;
    localparam int ADDR_LSB       = 0;

    typedef struct packed {
        logic [15:0]  length;
        logic [15:0]  their_port;
        logic [15:0]  my_port;
        logic [127:0] their_address;
    } udp_meta_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_META_OUT = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DROP     = 2'd3
    } echo_state_t;

endpackage : udp_echo_pkg
`default_nettype wire

// File: rtl/udp_echo_responder_keep_popcount.sv
`default_nettype none
// ============================================================================
// Module      : keep_popcount
// Description : Combinational count of set bits in an AXI-Stream keep vector.
// Ports       : keep  - byte-enable vector, KEEP_W bits
//               count - number of asserted keep bits (0..KEEP_W)
// Revision    : 1.0 - initial release
// ============================================================================
module keep_popcount #(
    parameter int KEEP_W = 8
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [7:0]        count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            count = count + {7'd0, keep[i]};
        end
    end

endmodule : keep_popcount
`default_nettype wire

// File: rtl/udp_echo_responder.sv
`default_nettype none
// ============================================================================
// Module      : udp_echo_responder
// Description : Echoes every received UDP datagram addressed to echo_port back
//               to its sender. Datagrams for other ports or longer than
//               MAX_LEN bytes are consumed and discarded. A per-datagram byte
//               counter flags payloads whose size disagrees with the metadata.
// Ports       : net_clk / net_aresetn      - clock, async active-low reset
//               s_axis_udp_rx_metadata_*   - received metadata (176 bit)
//               s_axis_udp_rx_data_*       - received payload stream
//               m_axis_udp_tx_metadata_*   - echo metadata (176 bit)
//               m_axis_udp_tx_data_*       - echo payload stream
//               echo_port                  - served local port
//               echo_count / drop_count / len_err_count - status counters
// Revision    : 1.0 - initial release
// ============================================================================
module udp_echo_responder
    import udp_echo_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int MAX_LEN = 1472
) (
    input  logic                  net_clk,
    input  logic                  net_aresetn,

    input  logic                  s_axis_udp_rx_metadata_valid,
    output logic                  s_axis_udp_rx_metadata_ready,
    input  logic [META_WIDTH-1:0] s_axis_udp_rx_metadata_data,

    input  logic                  s_axis_udp_rx_data_valid,
    output logic                  s_axis_udp_rx_data_ready,
    input  logic [WIDTH-1:0]      s_axis_udp_rx_data_data,
    input  logic [WIDTH/8-1:0]    s_axis_udp_rx_data_keep,
    input  logic                  s_axis_udp_rx_data_last,

    output logic                  m_axis_udp_tx_metadata_valid,
    input  logic                  m_axis_udp_tx_metadata_ready,
    output logic [META_WIDTH-1:0] m_axis_udp_tx_metadata_data,

    output logic                  m_axis_udp_tx_data_valid,
    input  logic                  m_axis_udp_tx_data_ready,
    output logic [WIDTH-1:0]      m_axis_udp_tx_data_data,
    output logic [WIDTH/8-1:0]    m_axis_udp_tx_data_keep,
    output logic                  m_axis_udp_tx_data_last,

    input  logic [15:0]           echo_port,
    output logic [31:0]           echo_count,
    output logic [31:0]           drop_count,
    output logic [31:0]           len_err_count
);

    localparam logic [15:0] C_MAX_LEN = 16'(MAX_LEN);

    echo_state_t r_state;
    udp_meta_t   r_meta;
    logic [15:0] r_byte_cnt;
    logic [31:0] r_echo_cnt;
    logic [31:0] r_drop_cnt;
    logic [31:0] r_len_err_cnt;

    udp_meta_t   w_meta_in;
    logic [7:0]  w_pop;
    logic [16:0] w_sum;
    logic [15:0] w_sum_sat;
    logic        w_beat;

    assign w_meta_in = udp_meta_t'(s_axis_udp_rx_metadata_data);

    keep_popcount #(
        .KEEP_W (WIDTH/8)
    ) u_keep_popcount (
        .keep  (s_axis_udp_rx_data_keep),
        .count (w_pop)
    );

    // Saturating running byte total including the current beat.
    assign w_sum     = {1'b0, r_byte_cnt} + {9'd0, w_pop};
    assign w_sum_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    // Handshake signals decoded from the registered state.
    assign s_axis_udp_rx_metadata_ready = (r_state == ST_IDLE);
    assign m_axis_udp_tx_metadata_valid = (r_state == ST_META_OUT);
    assign m_axis_udp_tx_metadata_data  = r_meta;

    // STREAM is a zero-latency pass-through; DROP sinks everything.
    assign m_axis_udp_tx_data_valid = (r_state == ST_STREAM) && s_axis_udp_rx_data_valid;
    assign m_axis_udp_tx_data_data  = s_axis_udp_rx_data_data;
    assign m_axis_udp_tx_data_keep  = s_axis_udp_rx_data_keep;
    assign m_axis_udp_tx_data_last  = s_axis_udp_rx_data_last;
    assign s_axis_udp_rx_data_ready = ((r_state == ST_STREAM) && m_axis_udp_tx_data_ready) ||
                                      (r_state == ST_DROP);

    assign w_beat = s_axis_udp_rx_data_valid && s_axis_udp_rx_data_ready;

    assign echo_count    = r_echo_cnt;
    assign drop_count    = r_drop_cnt;
    assign len_err_count = r_len_err_cnt;

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            r_state       <= ST_IDLE;
            r_meta        <= '0;
            r_byte_cnt    <= '0;
            r_echo_cnt    <= '0;
            r_drop_cnt    <= '0;
            r_len_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axis_udp_rx_metadata_valid) begin
                        // The my_port field is replaced by the sampled echo
                        // port so the registered struct is the reply header.
                        r_meta.length        <= w_meta_in.length;
                        r_meta.their_port    <= w_meta_in.their_port;
                        r_meta.my_port       <= echo_port;
                        r_meta.their_address <= w_meta_in.their_address;
                        r_byte_cnt           <= '0;
                        if ((w_meta_in.my_port == echo_port) &&
                            (w_meta_in.length <= C_MAX_LEN)) begin
                            r_state <= ST_META_OUT;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_META_OUT: begin
                    if (m_axis_udp_tx_metadata_ready) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM, ST_DROP: begin
                    if (w_beat) begin
                        r_byte_cnt <= w_sum_sat;
                        if (s_axis_udp_rx_data_last) begin
                            if (w_sum_sat != r_meta.length) begin
                                r_len_err_cnt <= r_len_err_cnt + 32'd1;
                            end
                            if (r_state == ST_STREAM) begin
                                r_echo_cnt <= r_echo_cnt + 32'd1;
                            end else begin
                                r_drop_cnt <= r_drop_cnt + 32'd1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : udp_echo_responder
`default_nettype wire

// File: tb/tb_udp_echo_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_echo_responder
// Description : Directed self-checking bench for udp_echo_responder (64 bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_echo_responder;

    logic         clk;
    logic         rst_n;
    logic         rmv, rmr;
    logic [175:0] rmd;
    logic         rdv, rdr;
    logic [63:0]  rdd;
    logic [7:0]   rdk;
    logic         rdl;
    logic         tmv, tmr;
    logic [175:0] tmd;
    logic         tdv, tdr;
    logic [63:0]  tdd;
    logic [7:0]   tdk;
    logic         tdl;
    logic [15:0]  eport;
    logic [31:0]  ecnt, dcnt, lcnt;

    int  n_total = 0;
    int  n_bad   = 0;
    bit  toggle  = 0;
    int  tx_beats = 0;

    localparam logic [127:0] IP = 128'h0A01D4D1;  // 10.1.212.209

    udp_echo_responder #(
        .WIDTH   (64),
        .MAX_LEN (1472)
    ) dut (
        .net_clk                      (clk),
        .net_aresetn                  (rst_n),
        .s_axis_udp_rx_metadata_valid (rmv),
        .s_axis_udp_rx_metadata_ready (rmr),
        .s_axis_udp_rx_metadata_data  (rmd),
        .s_axis_udp_rx_data_valid     (rdv),
        .s_axis_udp_rx_data_ready     (rdr),
        .s_axis_udp_rx_data_data      (rdd),
        .s_axis_udp_rx_data_keep      (rdk),
        .s_axis_udp_rx_data_last      (rdl),
        .m_axis_udp_tx_metadata_valid (tmv),
        .m_axis_udp_tx_metadata_ready (tmr),
        .m_axis_udp_tx_metadata_data  (tmd),
        .m_axis_udp_tx_data_valid     (tdv),
        .m_axis_udp_tx_data_ready     (tdr),
        .m_axis_udp_tx_data_data      (tdd),
        .m_axis_udp_tx_data_keep      (tdk),
        .m_axis_udp_tx_data_last      (tdl),
        .echo_port                    (eport),
        .echo_count                   (ecnt),
        .drop_count                   (dcnt),
        .len_err_count                (lcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tdv && tdr) tx_beats <= tx_beats + 1;
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_counters(input string tag, input int e, input int d, input int l);
        chk({tag, "_echo"}, ecnt, e);
        chk({tag, "_drop"}, dcnt, d);
        chk({tag, "_lenerr"}, lcnt, l);
    endtask

    task automatic send_meta(input logic [15:0] len, input logic [15:0] tport,
                             input logic [15:0] mport, input logic [127:0] ip);
        int g = 0;
        rmv = 1'b1;
        rmd = {len, tport, mport, ip};
        #1;
        while (!rmr) begin
            @(posedge clk); #1;
            g++;
            if (g > 50) begin
                chk("meta_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        rmv = 1'b0;
    endtask

    task automatic expect_meta(input logic [175:0] exp, input bit hold);
        chk("tx_meta_valid", tmv, 1);
        chk("tx_meta_data", tmd, exp);
        if (hold) begin
            @(posedge clk); #1;
            chk("tx_meta_hold_valid", tmv, 1);
            chk("tx_meta_hold_data", tmd, exp);
        end
        tmr = 1'b1;
        @(posedge clk); #1;
        tmr = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit echo);
        int g = 0;
        bit done = 0;
        rdv = 1'b1; rdd = d; rdk = k; rdl = l;
        while (!done) begin
            if (toggle) tdr = ~tdr;
            #1;
            if (echo) begin
                chk("rx_ready_mirror", rdr, tdr);
                chk("tx_data_valid", tdv, 1);
                chk("tx_data", tdd, d);
                chk("tx_keep", tdk, k);
                chk("tx_last", tdl, l);
            end else begin
                chk("drop_rx_ready", rdr, 1);
                chk("drop_no_tx_valid", tdv, 0);
            end
            done = rdr;
            @(posedge clk); #1;
            g++;
            if (!done && g > 20) begin
                chk("beat_timeout", 0, 1);
                done = 1;
            end
        end
        rdv = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int b0;
        rst_n = 0; rmv = 0; rmd = '0; rdv = 0; rdd = '0; rdk = '0; rdl = 0;
        tmr = 0; tdr = 1; eport = 16'd5001;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_rx_meta_ready", rmr, 1);
        chk("rst_tx_meta_valid", tmv, 0);
        chk("rst_tx_data_valid", tdv, 0);
        chk("rst_rx_data_ready", rdr, 0);
        chk_counters("rst", 0, 0, 0);

        // Echo: 16 bytes, two full beats; data held back while in META_OUT
        send_meta(16, 16'h1234, 16'd5001, IP);
        rdv = 1; rdd = 64'h1111_2222_3333_4444; rdk = 8'hFF; rdl = 0;
        #1;
        chk("metaout_rx_data_ready", rdr, 0);
        chk("metaout_no_tx_data", tdv, 0);
        expect_meta({16'd16, 16'h1234, 16'd5001, IP}, 1'b0);
        send_beat(64'h1111_2222_3333_4444, 8'hFF, 0, 1);
        send_beat(64'h5555_6666_7777_8888, 8'hFF, 1, 1);
        chk_counters("echo", 1, 0, 0);

        // Port mismatch: data arrives before metadata and is back-pressured
        rdv = 1; rdd = 64'hA1; rdk = 8'hFF; rdl = 0;
        #1;
        chk("early_data_ready0", rdr, 0);
        @(posedge clk); #1;
        chk("early_data_ready1", rdr, 0);
        send_meta(24, 16'h0042, 16'd5002, IP);
        chk("mismatch_no_tx_meta", tmv, 0);
        send_beat(64'hA1, 8'hFF, 0, 0);
        send_beat(64'hA2, 8'hFF, 0, 0);
        send_beat(64'hA3, 8'hFF, 1, 0);
        chk_counters("mismatch", 1, 1, 0);

        // Oversize: 1473 > MAX_LEN, one beat of 8 bytes also mismatches length
        send_meta(1473, 16'h0042, 16'd5001, IP);
        chk("oversize_no_tx_meta", tmv, 0);
        send_beat(64'hB1, 8'hFF, 1, 0);
        chk_counters("oversize", 1, 2, 1);

        // Exactly MAX_LEN: 184 full beats, echoed, held metadata stays stable
        send_meta(1472, 16'h0BEE, 16'd5001, IP);
        expect_meta({16'd1472, 16'h0BEE, 16'd5001, IP}, 1'b1);
        for (int i = 0; i < 184; i++) begin
            send_beat(64'(i) ^ 64'hC0DE_0000_0000_0000, 8'hFF, (i == 183), 1);
        end
        chk_counters("maxlen", 2, 2, 1);

        // Length error: metadata says 20, payload carries 12 bytes
        send_meta(20, 16'h0077, 16'd5001, IP);
        expect_meta({16'd20, 16'h0077, 16'd5001, IP}, 1'b0);
        send_beat(64'hD1, 8'hFF, 0, 1);
        send_beat(64'hD2, 8'h0F, 1, 1);
        chk_counters("lenerr", 3, 2, 2);

        // Zero length: single last beat with empty keep
        send_meta(0, 16'h0078, 16'd5001, IP);
        expect_meta({16'd0, 16'h0078, 16'd5001, IP}, 1'b0);
        send_beat(64'h0, 8'h00, 1, 1);
        chk_counters("zerolen", 4, 2, 2);

        // tx ready toggling each cycle: rx ready mirrors, 4 beats exactly
        send_meta(32, 16'h0079, 16'd5001, IP);
        expect_meta({16'd32, 16'h0079, 16'd5001, IP}, 1'b0);
        b0 = tx_beats;
        toggle = 1;
        for (int i = 0; i < 4; i++) send_beat(64'hE0 + 64'(i), 8'hFF, (i == 3), 1);
        toggle = 0;
        tdr = 1;
        chk("toggle_tx_beats", 32'(tx_beats - b0), 4);
        chk_counters("toggle", 5, 2, 2);

        // Back-to-back: next metadata accepted right after the last beat
        send_meta(8, 16'h0101, 16'd5001, IP);
        expect_meta({16'd8, 16'h0101, 16'd5001, IP}, 1'b0);
        send_beat(64'hF1, 8'hFF, 1, 1);
        chk("b2b_meta_ready", rmr, 1);
        send_meta(8, 16'h0202, 16'd5001, IP);
        expect_meta({16'd8, 16'h0202, 16'd5001, IP}, 1'b0);
        send_beat(64'hF2, 8'hFF, 1, 1);
        chk_counters("b2b", 7, 2, 2);

        // Reset during STREAM after beat 1 of 4
        send_meta(32, 16'h0303, 16'd5001, IP);
        expect_meta({16'd32, 16'h0303, 16'd5001, IP}, 1'b0);
        send_beat(64'h9001, 8'hFF, 0, 1);
        rdv = 1; rdd = 64'h9002; rdk = 8'hFF; rdl = 0;
        #1;
        chk("prerst_tx_valid", tdv, 1);
        rst_n = 0;
        #1;
        chk("inrst_tx_valid", tdv, 0);
        chk("inrst_rx_ready", rdr, 0);
        chk_counters("inrst", 0, 0, 0);
        rdv = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("postrst_meta_ready", rmr, 1);
        chk("postrst_tx_meta_valid", tmv, 0);
        send_meta(8, 16'h0404, 16'd5001, IP);
        expect_meta({16'd8, 16'h0404, 16'd5001, IP}, 1'b0);
        send_beat(64'h7777, 8'hFF, 1, 1);
        chk_counters("postrst", 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_udp_echo_responder
`default_nettype wire

// File: doc/udp_echo_responder.md
# udp_echo_responder

Role-side responder attached to the user ports of the UDP stack. It consumes received datagrams and returns each accepted payload to its sender: destination IP and port are taken from the received source, and the local port is set to the configured echo port. Datagrams for other ports, or longer than `MAX_LEN`, are consumed and discarded. Per-datagram byte counting detects metadata/payload length disagreement; the result is exposed as status counters.

## Interface
Parameters:
- `WIDTH`, 64 — data bus width in bits (64 or 512); keep is `WIDTH/8`.
- `MAX_LEN`, 1472 — largest payload length, in bytes, that is echoed.

Ports:
- `net_clk` in 1 — single clock.
- `net_aresetn` in 1 — asynchronous, active-low reset.
- `s_axis_udp_rx_metadata` axis_meta.slave 176 — received datagram metadata.
- `s_axis_udp_rx_data` axi_stream.slave WIDTH — received payload.
- `m_axis_udp_tx_metadata` axis_meta.master 176 — metadata for the echo datagram.
- `m_axis_udp_tx_data` axi_stream.master WIDTH — echo payload.
- `echo_port` in 16 — local UDP port that is served. Sampled at metadata acceptance.
- `echo_count` out 32 — number of datagrams echoed.
- `drop_count` out 32 — number of datagrams discarded.
- `len_err_count` out 32 — number of datagrams whose payload byte count differs from the metadata length.

## Operation
- Metadata layout, from MSB to LSB: `length[175:160]`, `their_port[159:144]`, `my_port[143:128]`, `their_address[127:0]`. `length` is the payload length in bytes.
- FSM states: IDLE, META_OUT, STREAM, DROP.
- **IDLE**
  - `s_axis_udp_rx_metadata.ready` = 1.
  - On a metadata handshake, the metadata is registered.
  - If `my_port == echo_port` and `length <= MAX_LEN`: go to META_OUT. Otherwise go to DROP.
  - A length of 0 is valid. It still carries one data beat with last = 1, and that beat may have keep all zero.
- **META_OUT**
  - `m_axis_udp_tx_metadata.valid` = 1.
  - Data is `{length, their_port, echo_port_sampled, their_address}`.
  - The metadata is held stable until ready.
  - On the handshake, go to STREAM.
- **STREAM** — combinational pass-through:
  - tx.valid = rx.valid; rx.ready = tx.ready.
  - data, keep and last are passed unchanged.
  - On the handshake of the last beat: `echo_count` +1, then go to IDLE.
- **DROP**
  - `s_axis_udp_rx_data.ready` = 1. Beats are discarded.
  - On the last beat: `drop_count` +1, then go to IDLE.
- **Byte counter** (16 bit, saturating at 0xFFFF)
  - Cleared on every metadata acceptance.
  - Adds popcount(keep) on every accepted data beat in STREAM or DROP.
  - On the last beat: if counter + popcount(keep) ≠ registered length, `len_err_count` +1.
  - Applies to both echoed and dropped datagrams.
  - Only the count is affected; forwarding still terminates on last.
- Rx data is never accepted in IDLE or META_OUT (rx data ready = 0). Data that arrives before its metadata is back-pressured.
- Status counters are 32 bit and wrap from 0xFFFFFFFF to 0.
- In a cycle where len_err and echo/drop increment together, both counters update.

## Timing
- Reset (async assert, synchronous-release usage): all of the following are cleared:
  - FSM to IDLE;
  - all counters to 0;
  - `m_axis_udp_tx_metadata.valid` = 0, `m_axis_udp_tx_data.valid` = 0, `s_axis_udp_rx_data.ready` = 0;
  - `s_axis_udp_rx_metadata.ready` = 1 after reset deassertion.
- A reset during STREAM or DROP abandons the datagram. Tx valid drops immediately.
- Latency, rx metadata handshake to tx metadata valid: 1 cycle.
- Latency, tx metadata handshake to first tx data valid: 0 cycles after entering STREAM. The next cycle after the metadata handshake can forward a beat.
- Data path latency in STREAM: 0 cycles (combinational).
- Minimum per-datagram overhead: 2 idle cycles on data (IDLE + META_OUT).
- Back-to-back datagrams: on the last-beat handshake the FSM enters IDLE, and the next metadata is accepted in that IDLE cycle.
- Valid, once asserted on either master port, stays asserted until the handshake.

## Structure
- Package `udp_echo_pkg`:
  - metadata field offsets;
  - `udp_meta_t` packed struct (176 bit);
  - `echo_state_t` enum;
  - `META_WIDTH = 176`.
- The module is monolithic.
- One natural sub-module: `keep_popcount` (parameter `WIDTH/8`, combinational, output 8 bit). It is shared with the future tx packetizer.

## Test plan
- Echo, 64 bit: metadata len=16, their_ip=10.1.212.209, their_port=0x1234, my_port=echo_port=5001, plus 2 full beats.
  - Required: tx metadata `{16, 0x1234, 5001, ip}` 1 cycle after acceptance.
  - Required: identical 2 beats out, last on beat 2.
  - Required: `echo_count`=1, `len_err_count`=0.
- Port mismatch: my_port=5002, echo_port=5001, 3 beats.
  - Required: all beats consumed with ready=1, no tx valid, `drop_count`=1.
- Oversize: len=1473, valid port.
  - Required: dropped, `drop_count`=1.
- Length error: metadata len=20, payload 2 beats with keep 0xFF, 0x0F (12 bytes).
  - Required: echoed, `echo_count`=1, `len_err_count`=1.
- Back-pressure and ordering:
  - Data beats presented before metadata → rx data ready stays 0.
  - tx data ready toggled 1/0 each cycle → rx ready mirrors it, no beat lost or duplicated.
  - Two back-to-back datagrams → second metadata accepted the cycle after the first last beat.
- Reset mid-STREAM: assert `net_aresetn`=0 after beat 1 of 4.
  - Required: tx valid=0 immediately, counters 0, FSM IDLE, and the next datagram echoes correctly.
